instr_fetch_queue: RTL and testbench

Parametrised next-generation instruction fetch stage. It generates sequential PCs, issues reads to a fixed-latency instruction memory, and buffers returned {pc, instr} pairs in a DEPTH-entry FIFO toward decode with a valid/ready handshake. It supports branch/jump redirect with flush of buffered and in-flight fetches. It sits between the PC source (branch resolution) and the decode stage, replacing the always-advancing single-register PC.

---
 rtl/instr_fetch_queue.sv | 109 ++++++++++
 tb/tb_instr_fetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: sequential PC generation, fixed 1-cycle-latency memory reads,
// and a DEPTH-entry {pc, instr} queue toward decode with branch/jump redirect flush.
module instr_fetch_queue #(
  parameter int                DBITS    = 32,
  parameter logic [DBITS-1:0]  START_PC = DBITS'(32'h40),
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 4,
  localparam int               CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             redirect,
  input  logic [DBITS-1:0] redirect_pc,
  output logic             imem_req,
  output logic [DBITS-1:0] imem_addr,
  input  logic [DBITS-1:0] imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_pc,
  output logic [DBITS-1:0] out_instr,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = CW + 1;

  // Handshake: decode takes the head entry on any rising edge where out_valid && out_ready;
  // out_valid never depends on out_ready, and out_pc/out_instr are held until taken.

  logic [DBITS-1:0] fetch_pc_q, fetch_pc_d;
  logic             inflight_q, inflight_d;
  logic [DBITS-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DBITS-1:0] pc_mem_q    [DEPTH];
  logic [DBITS-1:0] instr_mem_q [DEPTH];

  logic          deq;
  logic          enq;
  logic [OW-1:0] occ;

  assign out_valid = ~res & ~redirect & (count_q != '0);
  assign deq       = out_valid & out_ready;
  assign enq       = inflight_q & ~redirect & ~res;

  // Slots already promised (queued + in flight) minus the one leaving this cycle;
  // issuing only below DEPTH means a returning read always finds a free slot.
  assign occ       = {1'b0, count_q} + OW'(inflight_q) - OW'(deq);
  assign imem_req  = ~res & ~redirect & (occ < OW'(DEPTH));
  assign imem_addr = fetch_pc_q;

  assign out_pc    = pc_mem_q[head_q];
  assign out_instr = instr_mem_q[head_q];
  assign count     = count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (res) begin
      fetch_pc_d = START_PC;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else if (redirect) begin
      fetch_pc_d = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (imem_req) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + DBITS'(PC_STEP);
      end
      if (enq) tail_d = tail_q + PW'(1);
      if (deq) head_d = head_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    fetch_pc_q    <= fetch_pc_d;
    inflight_q    <= inflight_d;
    inflight_pc_q <= inflight_pc_d;
    head_q        <= head_d;
    tail_q        <= tail_d;
    count_q       <= count_d;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem_q[tail_q]    <= inflight_pc_q;
      instr_mem_q[tail_q] <= imem_rdata;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (res)
    (enq && !deq) |-> (count_q < CW'(DEPTH)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a per-cycle vector table plus hand-written
// redirect and PC-wrap sequences, against a memory that returns addr ^ 32'hFFFF.
module tb_instr_fetch_queue;

  localparam int DBITS = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             res = 1'b1;
  logic             redirect = 1'b0;
  logic [DBITS-1:0] redirect_pc = '0;
  logic             imem_req;
  logic [DBITS-1:0] imem_addr;
  logic [DBITS-1:0] imem_rdata = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DBITS-1:0] out_pc;
  logic [DBITS-1:0] out_instr;
  logic [CW-1:0]    count;

  int checks = 0;
  int errors = 0;

  instr_fetch_queue #(
    .DBITS(DBITS), .START_PC(32'h40), .DEPTH(DEPTH), .PC_STEP(4)
  ) dut (
    .clk(clk), .res(res), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .count(count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model: data for the address presented this cycle appears next cycle
  always @(posedge clk) imem_rdata <= imem_addr ^ 32'h0000_FFFF;

  typedef struct {
    logic        res;
    logic        redirect;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    int          e_count;
  } vec_t;

  vec_t vecs[$];

  // scoreboard of PCs expected in order at the output during the wrap sequence
  logic [DBITS-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    res = r;
    redirect = rd;
    redirect_pc = rpc;
    out_ready = rdy;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_valid, input logic [31:0] e_pc, input int e_count);
    check({tag, ".req"}, 32'(imem_req), 32'(e_req));
    if (e_req) check({tag, ".addr"}, imem_addr, e_addr);
    check({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
    if (e_valid) begin
      check({tag, ".pc"}, out_pc, e_pc);
      check({tag, ".instr"}, out_instr, e_pc ^ 32'h0000_FFFF);
    end
    check({tag, ".count"}, 32'(count), 32'(e_count));
  endtask

  function automatic vec_t v(input logic r, input logic rd, input logic [31:0] rpc,
                             input logic rdy, input logic er, input logic [31:0] ea,
                             input logic ev, input logic [31:0] ep, input int ec);
    vec_t x;
    x.res = r; x.redirect = rd; x.rpc = rpc; x.rdy = rdy;
    x.e_req = er; x.e_addr = ea; x.e_valid = ev; x.e_pc = ep; x.e_count = ec;
    return x;
  endfunction

  initial begin
    // reset sequence, table checks start with reset still asserted
    vecs.push_back(v(1, 0, 0, 1,  0, 0,     0, 0,     0));
    // streaming after reset release with out_ready high
    vecs.push_back(v(0, 0, 0, 1,  1, 'h40,  0, 0,     0));
    vecs.push_back(v(0, 0, 0, 1,  1, 'h44,  0, 0,     0));
    vecs.push_back(v(0, 0, 0, 1,  1, 'h48,  1, 'h40,  1));
    vecs.push_back(v(0, 0, 0, 1,  1, 'h4C,  1, 'h44,  1));
    vecs.push_back(v(0, 0, 0, 1,  1, 'h50,  1, 'h48,  1));
    // mid-stream reset, then fill with decode stalled
    vecs.push_back(v(1, 0, 0, 0,  0, 0,     0, 0,     1));
    vecs.push_back(v(1, 0, 0, 0,  0, 0,     0, 0,     0));
    vecs.push_back(v(0, 0, 0, 0,  1, 'h40,  0, 0,     0));
    vecs.push_back(v(0, 0, 0, 0,  1, 'h44,  0, 0,     0));
    vecs.push_back(v(0, 0, 0, 0,  1, 'h48,  1, 'h40,  1));
    vecs.push_back(v(0, 0, 0, 0,  1, 'h4C,  1, 'h40,  2));
    vecs.push_back(v(0, 0, 0, 0,  0, 0,     1, 'h40,  3));
    vecs.push_back(v(0, 0, 0, 0,  0, 0,     1, 'h40,  4));
    vecs.push_back(v(0, 0, 0, 0,  0, 0,     1, 'h40,  4));
    // release decode: drain in order, fetch resumes at 0x50 without gap
    vecs.push_back(v(0, 0, 0, 1,  1, 'h50,  1, 'h40,  4));
    vecs.push_back(v(0, 0, 0, 1,  1, 'h54,  1, 'h44,  3));
    vecs.push_back(v(0, 0, 0, 1,  1, 'h58,  1, 'h48,  3));
    vecs.push_back(v(0, 0, 0, 1,  1, 'h5C,  1, 'h4C,  3));
    vecs.push_back(v(0, 0, 0, 1,  1, 'h60,  1, 'h50,  3));
    // reset with a populated queue and a read in flight
    vecs.push_back(v(1, 0, 0, 1,  0, 0,     0, 0,     3));
    vecs.push_back(v(1, 0, 0, 1,  0, 0,     0, 0,     0));
    // reset and redirect together: reset wins
    vecs.push_back(v(1, 1, 'h300, 1,  0, 0, 0, 0,     0));
    vecs.push_back(v(0, 0, 0, 1,  1, 'h40,  0, 0,     0));
    vecs.push_back(v(0, 0, 0, 1,  1, 'h44,  0, 0,     0));
    vecs.push_back(v(0, 0, 0, 1,  1, 'h48,  1, 'h40,  1));

    drive(1, 0, 0, 1);
    next_cycle();
    next_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i].res, vecs[i].redirect, vecs[i].rpc, vecs[i].rdy);
      check_cycle($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                  vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_count);
      next_cycle();
    end

    // redirect with three queued entries and 0x4C in flight
    drive(1, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) next_cycle();
    check_cycle("pre_redir", 1'b0, 0, 1'b1, 32'h40, 3);
    drive(0, 1, 32'h200, 0);
    check_cycle("redir", 1'b0, 0, 1'b0, 0, 3);
    next_cycle();
    drive(0, 0, 0, 0);
    check_cycle("redir_p1", 1'b1, 32'h200, 1'b0, 0, 0);
    next_cycle();
    check_cycle("redir_p2", 1'b1, 32'h204, 1'b0, 0, 0);
    next_cycle();
    check_cycle("redir_p3", 1'b1, 32'h208, 1'b1, 32'h200, 1);

    // redirect near the top of the address space: PC wraps to zero
    next_cycle();
    drive(0, 1, 32'hFFFF_FFF8, 1);
    check("wrap_redir.valid", 32'(out_valid), 32'd0);
    next_cycle();
    drive(0, 0, 0, 1);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    check("wrap.addr0", imem_addr, 32'hFFFF_FFF8);
    next_cycle();
    next_cycle();
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
      if (out_valid) begin
        check("wrap.pc", out_pc, exp_q[0]);
        check("wrap.instr", out_instr, exp_q[0] ^ 32'h0000_FFFF);
        void'(exp_q.pop_front());
      end
      next_cycle();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap.drain: %0d entries never appeared, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
